// File: rtl/vc_mem_copy_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : vc_mem_copy_initiator
//  Description : Val/rdy memory-request initiator that copies a block of
//                full-width words from a source to a destination address,
//                one request outstanding at a time (read, write, repeat).
//                Data width must be a multiple of 8 and at least 16 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_mem_copy_initiator #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_count_nbits  = 16,
    localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int c_req_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits + p_data_nbits,
    localparam int c_resp_nbits  = 3 + p_opaque_nbits + c_len_nbits + p_data_nbits
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [p_addr_nbits-1:0]   src_addr,
    input  logic [p_addr_nbits-1:0]   dst_addr,
    input  logic [p_count_nbits-1:0]  nwords,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [p_count_nbits-1:0]  words_copied,
    output logic                      memreq_val,
    input  logic                      memreq_rdy,
    output logic [c_req_nbits-1:0]    memreq_msg,
    input  logic                      memresp_val,
    output logic                      memresp_rdy,
    input  logic [c_resp_nbits-1:0]   memresp_msg
);

    localparam logic [2:0]               c_type_read  = 3'd0;
    localparam logic [2:0]               c_type_write = 3'd1;
    localparam logic [c_len_nbits-1:0]   c_len_full   = '0;
    localparam logic [p_addr_nbits-1:0]  c_addr_step  = p_addr_nbits'(p_data_nbits / 8);
    localparam logic [p_count_nbits-1:0] c_count_one  = p_count_nbits'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [p_addr_nbits-1:0]    r_src;
    logic [p_addr_nbits-1:0]    r_dst;
    logic [p_count_nbits-1:0]   r_nwords;
    logic [p_count_nbits-1:0]   r_index;
    logic [p_data_nbits-1:0]    r_data;
    logic                       r_error;

    logic [2:0]                 w_resp_type;
    logic [p_opaque_nbits-1:0]  w_resp_opaque;
    logic [p_data_nbits-1:0]    w_resp_data;
    logic                       w_unused_resp_len;
    logic [p_opaque_nbits-1:0]  w_opaque;
    logic [p_count_nbits-1:0]   w_index_next;
    logic                       w_rd_ok;
    logic                       w_wr_ok;

    // Response field extraction; the length field carries no information here
    assign w_resp_type       = memresp_msg[c_resp_nbits-1 -: 3];
    assign w_resp_opaque     = memresp_msg[c_resp_nbits-4 -: p_opaque_nbits];
    assign w_resp_data       = memresp_msg[p_data_nbits-1:0];
    assign w_unused_resp_len = ^memresp_msg[p_data_nbits +: c_len_nbits];

    // Opaque tags each transaction with the low bits of the word index
    assign w_opaque     = p_opaque_nbits'(r_index);
    assign w_index_next = r_index + c_count_one;
    assign w_rd_ok      = (w_resp_type == c_type_read)  && (w_resp_opaque == w_opaque);
    assign w_wr_ok      = (w_resp_type == c_type_write) && (w_resp_opaque == w_opaque);

    assign words_copied = r_index;
    assign error        = r_error;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded handshake/status outputs
    always_comb begin
        w_state_next = r_state;
        memreq_val   = 1'b0;
        memresp_rdy  = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        memreq_msg   = {c_type_read, w_opaque, r_src, c_len_full, {p_data_nbits{1'b0}}};
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (nwords == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                memreq_val = 1'b1;
                if (memreq_rdy) begin
                    w_state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                memresp_rdy = 1'b1;
                if (memresp_val) begin
                    w_state_next = w_rd_ok ? ST_WR_REQ : ST_DONE;
                end
            end
            ST_WR_REQ: begin
                memreq_val = 1'b1;
                memreq_msg = {c_type_write, w_opaque, r_dst, c_len_full, r_data};
                if (memreq_rdy) begin
                    w_state_next = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                memresp_rdy = 1'b1;
                if (memresp_val) begin
                    if (!w_wr_ok || (w_index_next == r_nwords)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Copy parameters, captured read data, progress counter and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_nwords <= '0;
            r_index  <= '0;
            r_data   <= '0;
            r_error  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_src    <= src_addr;
                        r_dst    <= dst_addr;
                        r_nwords <= nwords;
                        r_index  <= '0;
                        r_error  <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (memresp_val) begin
                        if (w_rd_ok) begin
                            r_data <= w_resp_data;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (memresp_val) begin
                        if (w_wr_ok) begin
                            r_index <= w_index_next;
                            r_src   <= r_src + c_addr_step;
                            r_dst   <= r_dst + c_addr_step;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_mem_copy_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_mem_copy_initiator
//  Description : Directed self-checking bench for vc_mem_copy_initiator with a
//                behavioural test memory (optional random stalls and opaque
//                corruption) and a second 8-bit-address instance for wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_mem_copy_initiator;

    localparam int O       = 8;
    localparam int A       = 32;
    localparam int D       = 32;
    localparam int N       = 16;
    localparam int L       = 2;
    localparam int REQ_NB  = 3 + O + A + L + D;
    localparam int RESP_NB = 3 + O + L + D;
    localparam int A2      = 8;
    localparam int REQ2_NB = 3 + O + A2 + L + D;

    logic clk;
    logic reset = 1'b1;

    logic                start = 1'b0;
    logic [A-1:0]        src_addr = '0;
    logic [A-1:0]        dst_addr = '0;
    logic [N-1:0]        nwords = '0;
    logic                busy, done, error;
    logic [N-1:0]        words_copied;
    logic                memreq_val;
    logic                memreq_rdy = 1'b0;
    logic [REQ_NB-1:0]   memreq_msg;
    logic                memresp_val = 1'b0;
    logic                memresp_rdy;
    logic [RESP_NB-1:0]  memresp_msg = '0;

    logic                start2 = 1'b0;
    logic [A2-1:0]       src2 = '0;
    logic [A2-1:0]       dst2 = '0;
    logic [N-1:0]        nwords2 = '0;
    logic                busy2, done2, error2;
    logic [N-1:0]        words_copied2;
    logic                memreq_val2;
    wire                 memreq_rdy2 = 1'b1;
    logic [REQ2_NB-1:0]  memreq_msg2;
    logic                memresp_val2 = 1'b0;
    logic                memresp_rdy2;
    logic [RESP_NB-1:0]  memresp_msg2 = '0;

    // Memory model state
    logic [31:0] mem [logic [31:0]];
    logic        stall_mode = 1'b0;
    int          corrupt_rd = -1;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [7:0]  rd_op_q[$];
    logic [7:0]  wr_op_q[$];
    logic [7:0]  rd2_addr_q[$];
    logic [7:0]  wr2_addr_q[$];
    int          hold_viol = 0;
    int          done_cnt = 0;
    int          val_cycles = 0;
    logic        pending = 1'b0;
    logic        was_held = 1'b0;
    logic [REQ_NB-1:0] held_msg = '0;

    int n_pass = 0;
    int n_checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vc_mem_copy_initiator #(
        .p_opaque_nbits (O),
        .p_addr_nbits   (A),
        .p_data_nbits   (D),
        .p_count_nbits  (N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .nwords       (nwords),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_copied (words_copied),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memreq_msg   (memreq_msg),
        .memresp_val  (memresp_val),
        .memresp_rdy  (memresp_rdy),
        .memresp_msg  (memresp_msg)
    );

    vc_mem_copy_initiator #(
        .p_opaque_nbits (O),
        .p_addr_nbits   (A2),
        .p_data_nbits   (D),
        .p_count_nbits  (N)
    ) dut_wrap (
        .clk          (clk),
        .reset        (reset),
        .start        (start2),
        .src_addr     (src2),
        .dst_addr     (dst2),
        .nwords       (nwords2),
        .busy         (busy2),
        .done         (done2),
        .error        (error2),
        .words_copied (words_copied2),
        .memreq_val   (memreq_val2),
        .memreq_rdy   (memreq_rdy2),
        .memreq_msg   (memreq_msg2),
        .memresp_val  (memresp_val2),
        .memresp_rdy  (memresp_rdy2),
        .memresp_msg  (memresp_msg2)
    );

    // Test memory: samples handshakes at the edge, updates its drives 1 time unit later
    always @(posedge clk) begin : mem_model
        logic              rq_fire, rs_fire, rst_s;
        logic [REQ_NB-1:0] rq;
        logic [2:0]        t;
        logic [7:0]        op;
        logic [31:0]       ad, dt, rdat;
        rst_s   = reset;
        rq_fire = memreq_val && memreq_rdy;
        rs_fire = memresp_val && memresp_rdy;
        rq      = memreq_msg;
        if (was_held && !rst_s && (!memreq_val || memreq_msg !== held_msg)) hold_viol++;
        was_held = memreq_val && !memreq_rdy && !rst_s;
        held_msg = memreq_msg;
        #1;
        if (rst_s) begin
            pending = 1'b0;
        end else begin
            if (rs_fire) pending = 1'b0;
            if (rq_fire) begin
                t  = rq[REQ_NB-1 -: 3];
                op = rq[REQ_NB-4 -: 8];
                ad = rq[D+L +: A];
                dt = rq[D-1:0];
                if (t == 3'd0) begin
                    rdat = mem.exists(ad) ? mem[ad] : 32'hDEAD_BEEF;
                    rd_op_q.push_back(op);
                    if (rd_cnt == corrupt_rd) op = 8'h07;
                    rd_cnt++;
                    memresp_msg = {3'd0, op, 2'b00, rdat};
                end else begin
                    mem[ad] = dt;
                    wr_op_q.push_back(op);
                    wr_cnt++;
                    memresp_msg = {3'd1, op, 2'b00, 32'h0};
                end
                pending = 1'b1;
            end
        end
        memresp_val = pending && (!stall_mode || $urandom_range(0, 1) == 1);
        memreq_rdy  = !stall_mode || $urandom_range(0, 1) == 1;
    end

    // Always-ready echo memory for the 8-bit-address instance
    always @(posedge clk) begin : mem2_model
        logic               f;
        logic [REQ2_NB-1:0] rq;
        f  = memreq_val2 && !reset;
        rq = memreq_msg2;
        #1;
        memresp_val2 = f;
        if (f) begin
            memresp_msg2 = {rq[REQ2_NB-1 -: 3], rq[REQ2_NB-4 -: 8], 2'b00, 32'h5A5A_0000};
            if (rq[REQ2_NB-1 -: 3] == 3'd0) rd2_addr_q.push_back(rq[D+L +: A2]);
            else                            wr2_addr_q.push_back(rq[D+L +: A2]);
        end
    end

    // Count done pulses and request-valid cycles
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (memreq_val) val_cycles++;
    end

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 'x;
    endfunction

    // Pulse start in cycle 0; returns at the negedge of cycle 1
    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; nwords = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Advance until done is seen or the budget expires
    task automatic wait_done(input int cyc0, input int max, output int cyc);
        cyc = cyc0;
        while (!done && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
        n_checks++; if (words_copied !== 16'd0) $display("FAIL reset_words: got %0d want 0", words_copied); else n_pass++;
        n_checks++; if (memreq_val !== 1'b0) $display("FAIL reset_memreq_val: got %b want 0", memreq_val); else n_pass++;
        n_checks++; if (memresp_rdy !== 1'b0) $display("FAIL reset_memresp_rdy: got %b want 0", memresp_rdy); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_zero_length;
        int v0, d0, cyc;
        v0 = val_cycles; d0 = done_cnt;
        start_copy(32'h100, 32'h200, 16'd0);
        wait_done(1, 20, cyc);
        n_checks++; if (cyc !== 1) $display("FAIL zero_done_cycle: got %0d want 1", cyc); else n_pass++;
        n_checks++; if (words_copied !== 16'd0) $display("FAIL zero_words: got %0d want 0", words_copied); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL zero_error: got %b want 0", error); else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++; if (val_cycles - v0 !== 0) $display("FAIL zero_no_req: got %0d want 0", val_cycles - v0); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_basic_copy;
        int cyc, b;
        for (int i = 0; i < 4; i++) mem[32'h100 + 4 * i] = 32'hA0 + i;
        b = rd_op_q.size();
        start_copy(32'h100, 32'h200, 16'd4);
        wait_done(1, 60, cyc);
        n_checks++; if (cyc !== 17) $display("FAIL basic_done_cycle: got %0d want 17", cyc); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done: got %b want 0", busy); else n_pass++;
        n_checks++; if (words_copied !== 16'd4) $display("FAIL basic_words: got %0d want 4", words_copied); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL basic_error: got %b want 0", error); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_mem(32'h200 + 4 * i) !== 32'hA0 + i)
                $display("FAIL basic_mem[%0h]: got %0h want %0h", 32'h200 + 4 * i, rd_mem(32'h200 + 4 * i), 32'hA0 + i);
            else n_pass++;
            n_checks++;
            if (rd_op_q.size() <= b + i || rd_op_q[b + i] !== 8'(i))
                $display("FAIL basic_opaque%0d: got %0h want %0h", i, (rd_op_q.size() > b + i) ? rd_op_q[b + i] : 8'hxx, i);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL basic_done_one_cycle: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_backpressure;
        int cyc, d0;
        hold_viol = 0;
        d0 = done_cnt;
        stall_mode = 1'b1;
        start_copy(32'h100, 32'h240, 16'd4);
        wait_done(1, 600, cyc);
        n_checks++; if (done !== 1'b1) $display("FAIL bp_done_seen: got %b want 1 (after %0d cycles)", done, cyc); else n_pass++;
        stall_mode = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (hold_viol !== 0) $display("FAIL bp_msg_stable: got %0d violations want 0", hold_viol); else n_pass++;
        n_checks++; if (words_copied !== 16'd4) $display("FAIL bp_words: got %0d want 4", words_copied); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_mem(32'h240 + 4 * i) !== 32'hA0 + i)
                $display("FAIL bp_mem[%0h]: got %0h want %0h", 32'h240 + 4 * i, rd_mem(32'h240 + 4 * i), 32'hA0 + i);
            else n_pass++;
        end
    endtask

    task automatic test_response_check;
        int cyc, r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        corrupt_rd = rd_cnt + 1;
        start_copy(32'h100, 32'h280, 16'd4);
        wait_done(1, 60, cyc);
        n_checks++; if (cyc !== 7) $display("FAIL rc_done_cycle: got %0d want 7", cyc); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL rc_error: got %b want 1", error); else n_pass++;
        n_checks++; if (words_copied !== 16'd1) $display("FAIL rc_words: got %0d want 1", words_copied); else n_pass++;
        repeat (5) @(negedge clk);
        corrupt_rd = -1;
        n_checks++; if (rd_cnt - r0 !== 2) $display("FAIL rc_reads: got %0d want 2", rd_cnt - r0); else n_pass++;
        n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL rc_writes: got %0d want 1", wr_cnt - w0); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL rc_error_sticky: got %b want 1", error); else n_pass++;
        start_copy(32'h100, 32'h2C0, 16'd1);
        n_checks++; if (error !== 1'b0) $display("FAIL rc_error_cleared: got %b want 0", error); else n_pass++;
        wait_done(1, 60, cyc);
        n_checks++; if (cyc !== 5) $display("FAIL rc_retry_cycle: got %0d want 5", cyc); else n_pass++;
        n_checks++; if (rd_mem(32'h2C0) !== 32'hA0) $display("FAIL rc_retry_mem: got %0h want a0", rd_mem(32'h2C0)); else n_pass++;
    endtask

    task automatic test_reset_mid_copy;
        start_copy(32'h100, 32'h500, 16'd4);
        repeat (7) @(negedge clk);
        n_checks++; if (memresp_rdy !== 1'b1) $display("FAIL rst_mid_in_wait: got %b want 1", memresp_rdy); else n_pass++;
        n_checks++; if (words_copied !== 16'd1) $display("FAIL rst_mid_words_before: got %0d want 1", words_copied); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (memreq_val !== 1'b0) $display("FAIL rst_mid_memreq_val: got %b want 0", memreq_val); else n_pass++;
        n_checks++; if (words_copied !== 16'd0) $display("FAIL rst_mid_words: got %0d want 0", words_copied); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ignored_start;
        int cyc;
        start_copy(32'h100, 32'h300, 16'd2);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; src_addr = 32'h180; dst_addr = 32'h400; nwords = 16'd4;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, 60, cyc);
        n_checks++; if (cyc !== 9) $display("FAIL ign_done_cycle: got %0d want 9", cyc); else n_pass++;
        start = 1'b1; nwords = 16'd3;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_start_in_done: got busy %b want 0", busy); else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++; if (words_copied !== 16'd2) $display("FAIL ign_words: got %0d want 2", words_copied); else n_pass++;
        n_checks++; if (rd_mem(32'h304) !== 32'hA1) $display("FAIL ign_mem304: got %0h want a1", rd_mem(32'h304)); else n_pass++;
        n_checks++; if (mem.exists(32'h308) !== 1'b0) $display("FAIL ign_no_third_word: got %0d want 0", mem.exists(32'h308)); else n_pass++;
        n_checks++; if (mem.exists(32'h400) !== 1'b0) $display("FAIL ign_no_new_dst: got %0d want 0", mem.exists(32'h400)); else n_pass++;
    endtask

    task automatic test_addr_wrap;
        int cyc;
        @(negedge clk);
        start2 = 1'b1; src2 = 8'hFC; dst2 = 8'h10; nwords2 = 16'd2;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc !== 9) $display("FAIL wrap_done_cycle: got %0d want 9", cyc); else n_pass++;
        n_checks++; if (rd2_addr_q.size() !== 2) $display("FAIL wrap_read_count: got %0d want 2", rd2_addr_q.size()); else n_pass++;
        if (rd2_addr_q.size() == 2) begin
            n_checks++; if (rd2_addr_q[0] !== 8'hFC) $display("FAIL wrap_rd0: got %0h want fc", rd2_addr_q[0]); else n_pass++;
            n_checks++; if (rd2_addr_q[1] !== 8'h00) $display("FAIL wrap_rd1: got %0h want 00", rd2_addr_q[1]); else n_pass++;
        end
        if (wr2_addr_q.size() == 2) begin
            n_checks++; if (wr2_addr_q[1] !== 8'h14) $display("FAIL wrap_wr1: got %0h want 14", wr2_addr_q[1]); else n_pass++;
        end
        n_checks++; if (words_copied2 !== 16'd2) $display("FAIL wrap_words: got %0d want 2", words_copied2); else n_pass++;
        n_checks++; if (error2 !== 1'b0) $display("FAIL wrap_error: got %b want 0", error2); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_zero_length;
        test_basic_copy;
        test_backpressure;
        test_response_check;
        test_reset_mid_copy;
        test_ignored_start;
        test_addr_wrap;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vc_mem_copy_initiator.md
Name: vc_mem_copy_initiator

Overview:
- Memory-request initiator that copies a block of `nwords` full-width words from `src_addr` to `dst_addr`.
- Uses one val/rdy memory request port and one val/rdy memory response port in the standard VC mem message format.
- Sits on the requester side of a test memory port; used to exercise the memory system and to serve as a DMA-style traffic source in tests.
- Strictly one request outstanding: read word, write word, repeat.

Parameters:
- p_opaque_nbits, 8, opaque field width (o)
- p_addr_nbits, 32, address field width (a)
- p_data_nbits, 32, data field width (d); must be a multiple of 8
- p_count_nbits, 16, width of word count and progress counter

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a copy; honoured only when busy=0
- src_addr  input  a  source byte address, sampled when start is honoured
- dst_addr  input  a  destination byte address, sampled when start is honoured
- nwords  input  p_count_nbits  number of words to copy, sampled when start is honoured
- busy  output  1  high from the cycle after an honoured start until DONE
- done  output  1  one-cycle pulse in the DONE state
- error  output  1  sticky response-check failure flag
- words_copied  output  p_count_nbits  number of words whose write response has been received
- memreq_val  output  1  request valid
- memreq_rdy  input  1  request ready
- memreq_msg  output  VC_MEM_REQ_MSG_NBITS(o,a,d)  request, fields {type,opaque,addr,len,data}
- memresp_val  input  1  response valid
- memresp_rdy  output  1  response ready
- memresp_msg  input  VC_MEM_RESP_MSG_NBITS(o,d)  response, fields {type,opaque,len,data}

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: FSM goes to IDLE. busy=0, done=0, error=0, words_copied=0, memreq_val=0, memresp_rdy=0.
- Reset mid-copy: same as above; the copy is abandoned. The memory's queues share the same reset, so no stale responses remain.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - On start=1, latch src, dst and nwords; clear error and words_copied.
  - If nwords==0, go to DONE; otherwise go to RD_REQ.
- RD_REQ:
  - memreq_val=1 with type=READ, opaque=index[o-1:0], addr=src_cur, len=0, data=0.
  - Hold the message stable until memreq_rdy=1 (fire), then go to RD_WAIT.
- RD_WAIT:
  - memresp_rdy=1.
  - On memresp_val, check type==READ and opaque==index[o-1:0].
  - Pass: capture data into the data register and go to WR_REQ. Fail: set error and go to DONE.
- WR_REQ:
  - memreq_val=1 with type=WRITE, opaque=index[o-1:0], addr=dst_cur, len=0 (full width), data=captured word.
  - On fire, go to WR_WAIT.
- WR_WAIT:
  - memresp_rdy=1.
  - On memresp_val, check type==WRITE and opaque==index[o-1:0]. Fail: set error and go to DONE.
  - Pass: increment words_copied and index; advance src_cur and dst_cur by d/8.
  - Then go to DONE if the new index==nwords, else to RD_REQ.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- start while busy (any non-IDLE state, including DONE) is ignored.
- memreq_val and memresp_rdy are registered-state decodes only. No combinational path from memresp_* to memreq_* or from memreq_rdy to memresp_rdy.
- A response arriving in a non-WAIT state is not accepted (memresp_rdy=0).
- Address arithmetic is modulo 2^a and wraps silently. index is modulo 2^p_count_nbits; opaque is its low o bits.
- Latency against a memory that accepts immediately and responds next cycle:
  - each state takes 1 cycle, so each word costs 4 cycles;
  - with start in cycle 0, done pulses in cycle 4*nwords+1.
- Memory stalls (rdy=0 or val=0) extend the current state indefinitely. Nothing times out.

Test Plan:
- Zero-length copy: start with nwords=0 -> no memreq_val; done in cycle 1; words_copied=0; error=0.
- Basic copy: preload 0x100..0x10C with 0xA0,0xA1,0xA2,0xA3; start with src=0x100, dst=0x200, nwords=4, zero-latency memory -> done in cycle 17; mem[0x200..0x20C]=0xA0..0xA3; words_copied=4; opaques seen 0,1,2,3.
- Backpressure: random memreq_rdy/memresp_val stalls (50%) on the same copy -> identical memory contents; memreq_msg stable while val=1 and rdy=0; done exactly once.
- Response check: corrupt the opaque of the 2nd read response to 0x7 -> error=1, done pulses, words_copied=1, no further requests; a new start clears error.
- Reset and ignored start: assert reset in WR_WAIT of word 2 -> next cycle busy=0, memreq_val=0, words_copied=0. A start pulse while busy -> ignored; the copy completes with the original parameters.
- Address wrap: a=8, src=0xFC, nwords=2 -> read addresses 0xFC then 0x00.
